// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: sample stream, FFT core pins and result bus of the frame sequencer
interface fft_frame_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic              sample_valid;
  logic [15:0]       sample_in;
  logic              sample_ready;
  logic              fft_rst;
  logic              fft_load;
  logic [ADDR_W-1:0] fft_load_address;
  logic [31:0]       fft_data_in;
  logic              fft_start;
  logic              fft_done;
  logic [31:0]       fft_data_out;
  logic              result_valid;
  logic [ADDR_W-1:0] result_index;
  logic [15:0]       result_re;
  logic [15:0]       result_im;
  logic              result_last;
  modport master (
    input  sample_valid, sample_in, fft_done, fft_data_out,
    output sample_ready, fft_rst, fft_load, fft_load_address, fft_data_in, fft_start,
           result_valid, result_index, result_re, result_im, result_last
  );
  modport slave (
    output sample_valid, sample_in, fft_done, fft_data_out,
    input  sample_ready, fft_rst, fft_load, fft_load_address, fft_data_in, fft_start,
           result_valid, result_index, result_re, result_im, result_last
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames mic samples into the FFT core, starts it and drains its spectrum bins
module fft_frame_sequencer #(
  parameter int N_POINTS = 512,
  parameter int TIMEOUT  = 8192,
  parameter int RST_CYC  = 4,
  parameter int ADDR_W   = $clog2(N_POINTS)
) (
  input  logic                 slow_clk,
  input  logic                 reset,
  input  logic                 enable_i,
  output logic                 busy_o,
  output logic                 timeout_err_o,
  fft_frame_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);
  typedef enum logic [2:0] {S_RST, S_IDLE, S_LOAD, S_START, S_WAIT, S_READ} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [RC_W-1:0]   rc_cnt_q, rc_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic              sample_ready_q, sample_ready_d;
  logic              fft_rst_q, fft_rst_d;
  logic              fft_load_q, fft_load_d;
  logic [ADDR_W-1:0] fft_addr_q, fft_addr_d;
  logic [31:0]       fft_data_q, fft_data_d;
  logic              fft_start_q, fft_start_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;
  logic [15:0]       res_re_q, res_re_d;
  logic [15:0]       res_im_q, res_im_d;
  logic              res_last_q, res_last_d;
  logic              xfer;
  logic              cap;
  // Bin 0 is already on fft_data_out in the cycle done first rises, so WAIT captures too.
  assign xfer = sample_ready_q & bus.sample_valid;
  assign cap  = bus.fft_done & (state_q == S_WAIT | state_q == S_READ);
  // Next state, frame counters and watchdog.
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    rc_cnt_d      = rc_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_RST: begin
        rc_cnt_d = rc_cnt_q + 1'b1;
        if (rc_cnt_q == RC_W'(RST_CYC - 1)) state_d = S_IDLE;
      end
      S_IDLE: if (enable_i) begin
        state_d  = S_LOAD;
        ld_cnt_d = '0;
      end
      S_LOAD: if (xfer) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        if (ld_cnt_q == LAST) state_d = S_START;
      end
      S_START: begin
        state_d  = S_WAIT;
        wd_cnt_d = '0;
        rd_cnt_d = '0;
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (bus.fft_done) state_d = S_READ;
        else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          rc_cnt_d      = '0;
          state_d       = S_RST;
        end
      end
      default: ;
    endcase
    if (cap) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) begin
        state_d  = enable_i ? S_LOAD : S_IDLE;
        ld_cnt_d = '0;
      end
    end
  end
  // Registered output values derived from the next state and this cycle's transfers.
  always_comb begin
    sample_ready_d = state_d == S_LOAD;
    busy_d         = state_d != S_IDLE;
    fft_rst_d      = state_d == S_RST;
    fft_start_d    = state_d == S_START;
    fft_load_d     = xfer;
    fft_addr_d     = xfer ? ld_cnt_q : fft_addr_q;
    fft_data_d     = xfer ? {bus.sample_in, 16'h0000} : fft_data_q;
    res_valid_d    = cap;
    res_index_d    = cap ? rd_cnt_q : res_index_q;
    res_re_d       = cap ? bus.fft_data_out[31:16] : res_re_q;
    res_im_d       = cap ? bus.fft_data_out[15:0] : res_im_q;
    res_last_d     = cap && rd_cnt_q == LAST;
  end
  // State and output registers; reset aborts any frame and holds the core in reset.
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      state_q        <= S_RST;
      ld_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      wd_cnt_q       <= '0;
      rc_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      sample_ready_q <= 1'b0;
      fft_rst_q      <= 1'b1;
      fft_load_q     <= 1'b0;
      fft_addr_q     <= '0;
      fft_data_q     <= '0;
      fft_start_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_index_q    <= '0;
      res_re_q       <= '0;
      res_im_q       <= '0;
      res_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      rc_cnt_q       <= rc_cnt_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
      sample_ready_q <= sample_ready_d;
      fft_rst_q      <= fft_rst_d;
      fft_load_q     <= fft_load_d;
      fft_addr_q     <= fft_addr_d;
      fft_data_q     <= fft_data_d;
      fft_start_q    <= fft_start_d;
      res_valid_q    <= res_valid_d;
      res_index_q    <= res_index_d;
      res_re_q       <= res_re_d;
      res_im_q       <= res_im_d;
      res_last_q     <= res_last_d;
    end
  end
  assign busy_o               = busy_q;
  assign timeout_err_o        = timeout_err_q;
  assign bus.sample_ready     = sample_ready_q;
  assign bus.fft_rst          = fft_rst_q;
  assign bus.fft_load         = fft_load_q;
  assign bus.fft_load_address = fft_addr_q;
  assign bus.fft_data_in      = fft_data_q;
  assign bus.fft_start        = fft_start_q;
  assign bus.result_valid     = res_valid_q;
  assign bus.result_index     = res_index_q;
  assign bus.result_re        = res_re_q;
  assign bus.result_im        = res_im_q;
  assign bus.result_last      = res_last_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: scoreboard bench with a behavioural FFT core for the frame sequencer
module tb_fft_frame_sequencer;
  localparam int N  = 512;
  localparam int AW = 9;
  logic slow_clk = 1'b0;
  logic reset    = 1'b0;
  logic enable   = 1'b0;
  logic busy, timeout_err;
  int   tests = 0, fails = 0, start_cnt = 0, last_cnt = 0, core_mode = 0;
  bit   abort = 1'b0, prev_start = 1'b0;
  logic [40:0] load_q[$];
  logic [41:0] res_q[$];
  fft_frame_sequencer_if #(.ADDR_W(AW)) bus ();
  fft_frame_sequencer #(.N_POINTS(N), .TIMEOUT(64), .RST_CYC(4)) dut (
    .slow_clk(slow_clk), .reset(reset), .enable_i(enable),
    .busy_o(busy), .timeout_err_o(timeout_err), .bus(bus)
  );
  always #5 slow_clk = ~slow_clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, "_fft_rst"}, 64'(bus.fft_rst), 64'd1);
    check({name, "_outs_a"}, 64'({bus.sample_ready, bus.fft_load, bus.fft_start, bus.result_valid,
      bus.result_last, busy, timeout_err, bus.fft_load_address, bus.fft_data_in}), 64'd0);
    check({name, "_outs_b"}, 64'({bus.result_index, bus.result_re, bus.result_im}), 64'd0);
  endtask
  // Monitor: pop expected loads/bins whenever the DUT presents them.
  initial forever begin
    @(negedge slow_clk);
    if (bus.fft_load === 1'b1) begin
      if (load_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_load: got addr %0h data %0h, none expected", bus.fft_load_address, bus.fft_data_in);
      end else check("load", 64'({bus.fft_load_address, bus.fft_data_in}), 64'(load_q.pop_front()));
    end
    if (bus.result_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_result: got index %0d, none expected", bus.result_index);
      end else check("result", 64'({bus.result_index, bus.result_re, bus.result_im, bus.result_last}), 64'(res_q.pop_front()));
    end
    if (bus.fft_start === 1'b1) begin
      start_cnt++;
      check("start_single_cycle", 64'(prev_start), 64'd0);
    end
    prev_start = bus.fft_start === 1'b1;
    if (bus.result_last === 1'b1) last_cnt++;
  end
  // Core model: after a start, present bin i = {3*i, 0x8000+i}; mode 1 stalls at bin 300, mode 2 never finishes.
  initial begin
    logic [15:0] re, im;
    bus.fft_done     = 1'b0;
    bus.fft_data_out = '0;
    forever begin
      @(negedge slow_clk);
      if (bus.fft_start === 1'b1 && core_mode != 2) begin
        repeat (5) @(negedge slow_clk);
        for (int i = 0; i < N; i++) begin
          if (abort) break;
          if (core_mode == 1 && i == 300) begin
            bus.fft_done = 1'b0;
            repeat (2) @(negedge slow_clk);
          end
          re = 16'(3 * i);
          im = 16'(32768 + i);
          bus.fft_done     = 1'b1;
          bus.fft_data_out = {re, im};
          res_q.push_back({AW'(i), re, im, i == N - 1});
          @(negedge slow_clk);
        end
        bus.fft_done = 1'b0;
      end
    end
  end
  task automatic send_frame(input bit gap, input logic [15:0] base, input int drop_at);
    int k = 0;
    int cyc = 0;
    while (k < N && cyc < 4000) begin
      @(negedge slow_clk);
      cyc++;
      bus.sample_valid = !gap || (cyc % 2 == 0);
      bus.sample_in    = base + 16'(k);
      if (bus.sample_valid && bus.sample_ready === 1'b1) begin
        load_q.push_back({AW'(k), base + 16'(k), 16'h0000});
        if (k == drop_at) enable = 1'b0;
        k++;
      end
    end
    check("frame_loaded", 64'(k), 64'(N));
    @(negedge slow_clk);
    bus.sample_valid = 1'b0;
  endtask
  task automatic wait_last(input int target);
    int g = 0;
    while (last_cnt < target && g < 3000) begin
      @(negedge slow_clk);
      g++;
    end
    check("frame_drained", 64'(last_cnt), 64'(target));
  endtask
  task automatic rst_pulse(output int n);
    n = 0;
    while (bus.fft_rst === 1'b1 && n < 50) begin
      n++;
      @(negedge slow_clk);
    end
  endtask
  // Directed sequence: power-up, ramp, gappy+stall, enable drop, watchdog, reset mid-READ.
  initial begin
    int n;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    repeat (3) @(negedge slow_clk);
    check_reset_outputs("por");
    reset = 1'b1;
    rst_pulse(n);
    check("por_rst_len", 64'(n), 64'd4);
    check("idle_busy", 64'({busy, bus.sample_ready}), 64'd0);
    bus.sample_valid = 1'b1;
    repeat (4) @(negedge slow_clk);
    bus.sample_valid = 1'b0;
    check("idle_ignores_valid", 64'({busy, bus.sample_ready}), 64'd0);
    enable = 1'b1;
    send_frame(1'b0, 16'h0000, -1);
    wait_last(1);
    check("starts_ramp", 64'(start_cnt), 64'd1);
    core_mode = 1;
    send_frame(1'b1, 16'h8000, -1);
    wait_last(2);
    check("starts_gappy", 64'(start_cnt), 64'd2);
    core_mode = 0;
    send_frame(1'b0, 16'h1234, 100);
    wait_last(3);
    repeat (3) @(negedge slow_clk);
    check("drop_idle", 64'({busy, bus.sample_ready}), 64'd0);
    check("starts_drop", 64'(start_cnt), 64'd3);
    core_mode = 2;
    enable = 1'b1;
    send_frame(1'b0, 16'hFF00, -1);
    n = 0;
    while (bus.fft_start !== 1'b1 && n < 100) begin
      @(negedge slow_clk);
      n++;
    end
    check("start_seen", 64'(bus.fft_start), 64'd1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      @(negedge slow_clk);
      n++;
    end
    check("wd_cycles", 64'(n), 64'd65);
    rst_pulse(n);
    check("timeout_rst_len", 64'(n), 64'd4);
    core_mode = 0;
    send_frame(1'b0, 16'h0F0F, -1);
    wait_last(4);
    check("timeout_sticky", 64'(timeout_err), 64'd1);
    check("starts_recover", 64'(start_cnt), 64'd5);
    send_frame(1'b0, 16'h0055, -1);
    n = 0;
    while (!(bus.result_valid === 1'b1 && bus.result_index == AW'(200)) && n < 2000) begin
      @(negedge slow_clk);
      n++;
    end
    check("reached_bin200", 64'(bus.result_index), 64'd200);
    reset  = 1'b0;
    abort  = 1'b1;
    enable = 1'b0;
    @(negedge slow_clk);
    check_reset_outputs("mid_read");
    res_q.delete();
    repeat (3) @(negedge slow_clk);
    check("no_last_after_abort", 64'(last_cnt), 64'd4);
    abort = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge slow_clk);
    check("res_q_empty", 64'(res_q.size()), 64'd0);
    check("load_q_empty", 64'(load_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
